// File: rtl/mysystem_nios2_oci_trace_monitor.sv
// Trace monitor: captures DCT fragments into a show-ahead FIFO, tracks drops, sequences end-of-test drain.
// Optional per-word timestamp field enabled by defining MYSYSTEM_OCI_TRACE_TIMESTAMP_EN.
//
// state   | meaning
// CAPTURE | accepting trace fragments into the FIFO
// FLUSH   | captures ignored, FIFO draining to the sink
// DONE    | drain finished or abandoned; terminal until reset
module mysystem_nios2_oci_trace_monitor #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int LVL_W = $clog2(DEPTH + 1),
`ifdef MYSYSTEM_OCI_TRACE_TIMESTAMP_EN
  localparam int OUT_W = TS_W + CNT_W + DATA_W
`else
  localparam int OUT_W = CNT_W + DATA_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_valid,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fill_level,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic              flush_done
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_check
    $error("mysystem_nios2_oci_trace_monitor: DEPTH must be a power of 2 >= 2 and TS_W >= 1");
  end

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OUT_W-1:0] wr_word;
  logic             full;
  logic             empty;
  logic             pop;
  logic             req;
  logic             push;
  logic             drop;

`ifdef MYSYSTEM_OCI_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  assign wr_word = {ts, dct_count, dct_buffer};
`else
  assign wr_word = {dct_count, dct_buffer};
`endif

  assign full       = (fill_level == LVL_W'(DEPTH));
  assign empty      = (fill_level == '0);
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  // A hard stop clears the FIFO, so a capture in that cycle is neither stored nor a drop.
  assign req        = dct_valid && (dct_count != '0) && (state == ST_CAPTURE) && !test_has_ended;
  assign push       = req && (!full || pop);
  assign drop       = req && !push;
  assign out_data   = mem[rd_ptr];
  assign flush_done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CAPTURE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CAPTURE: if (test_ending) state_next = ST_FLUSH;
      // No pushes happen in FLUSH, so the last word leaving means empty next cycle.
      ST_FLUSH:   if (empty || (fill_level == LVL_W'(1) && pop)) state_next = ST_DONE;
      ST_DONE:    state_next = ST_DONE;
      default:    state_next = ST_CAPTURE;
    endcase
    if (test_has_ended) state_next = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset || test_has_ended) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + LVL_W'(1);
        2'b01:   fill_level <= fill_level - LVL_W'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule
